// File: rtl/distortion_pipeline.sv
// -----------------------------------------------------------------------------
// distortion_pipeline
//   Four-stage valid/ready pipeline for time-multiplexed signed samples:
//     S1 capture sample, channel tag and control snapshot
//     S2 fixed-point gain with saturation
//     S3 clipper (bypass / hard symmetric / asymmetric)
//     S4 fixed-point output volume with saturation (this is the output register)
//   A saturating counter tracks clipped samples leaving the block.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-low reset
//   enable           0 = samples pass through unmodified (same latency)
//   mode             00 bypass, 01 hard clip, 10 asymmetric clip, 11 as 01
//   in, in_chan      signed input sample and its channel tag
//   in_valid/ready   input handshake
//   gain             unsigned Q(WIDTH-GAIN_FRAC).GAIN_FRAC gain setting
//   threshold        unsigned clip magnitude (clamped to 2^(WIDTH-1)-1)
//   volume           unsigned Q(WIDTH-VOL_FRAC).VOL_FRAC volume setting
//   clip_clear       synchronous clear of clip_count
//   out, out_chan    processed sample and aligned channel tag
//   out_clipped      sample was modified by the clipper
//   out_valid/ready  output handshake
//   clip_count       saturating count of clipped samples transferred out
// -----------------------------------------------------------------------------
module distortion_pipeline #(
  parameter int WIDTH     = 16,
  parameter int GAIN_FRAC = 8,
  parameter int VOL_FRAC  = 8,
  parameter int CHANNELS  = 2,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic [CH_W-1:0]  in_chan,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gain,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] volume,
  input  logic             clip_clear,
  output logic [WIDTH-1:0] out,
  output logic [CH_W-1:0]  out_chan,
  output logic             out_clipped,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] clip_count
);

  localparam logic [WIDTH-1:0] P_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] P_NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Saturate a (2*WIDTH+1)-bit signed value to WIDTH bits: in range when all
  // bits from the WIDTH-1 sign position upward agree.
  function automatic logic [WIDTH-1:0] f_sat(input logic signed [2*WIDTH:0] v);
    if ((&v[2*WIDTH:WIDTH-1]) || !(|v[2*WIDTH:WIDTH-1])) begin
      return v[WIDTH-1:0];
    end else if (v[2*WIDTH]) begin
      return P_NEG_MIN;
    end else begin
      return P_POS_MAX;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic             r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
  logic [WIDTH-1:0] r_s1_data,  r_s2_data,  r_s3_data,  r_s4_data;
  logic [CH_W-1:0]  r_s1_chan,  r_s2_chan,  r_s3_chan,  r_s4_chan;
  logic             r_s1_en,    r_s2_en,    r_s3_en;
  logic             r_s1_clip_on, r_s2_clip_on;
  logic             r_s1_asym,    r_s2_asym;
  logic [WIDTH-1:0] r_s1_gain;
  logic [WIDTH-1:0] r_s1_thr,   r_s2_thr;
  logic [WIDTH-1:0] r_s1_vol,   r_s2_vol,   r_s3_vol;
  logic             r_s3_clipped, r_s4_clipped;
  logic [CNT_W-1:0] r_clip_count;

  logic w_advance;

  // The whole pipe moves as one; a stall only happens when the output
  // register is full and not being drained.
  assign w_advance = !r_s4_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------------------------------------------------------------------
  // S2 gain: signed sample times unsigned gain, floor shift, saturate
  // ---------------------------------------------------------------------------
  logic signed [2*WIDTH:0] w_gain_x, w_gain_k, w_gain_prod, w_gain_shift;
  logic        [WIDTH-1:0] w_s2_next;

  assign w_gain_x     = {{(WIDTH+1){r_s1_data[WIDTH-1]}}, r_s1_data};
  assign w_gain_k     = {{(WIDTH+1){1'b0}}, r_s1_gain};
  assign w_gain_prod  = w_gain_x * w_gain_k;
  assign w_gain_shift = w_gain_prod >>> GAIN_FRAC;
  assign w_s2_next    = r_s1_en ? f_sat(w_gain_shift) : r_s1_data;

  // ---------------------------------------------------------------------------
  // S3 clipper
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] w_clip_x, w_upper, w_lower;
  logic        [WIDTH-1:0] w_s3_next;
  logic                    w_s3_clipped;

  assign w_clip_x = $signed(r_s2_data);
  // Threshold was clamped at capture, so its MSB is 0 and negation cannot wrap.
  assign w_upper  = $signed(r_s2_thr);
  assign w_lower  = r_s2_asym ? -$signed({1'b0, r_s2_thr[WIDTH-1:1]})
                              : -$signed(r_s2_thr);

  always_comb begin
    w_s3_next    = r_s2_data;
    w_s3_clipped = 1'b0;
    if (r_s2_en && r_s2_clip_on) begin
      if (w_clip_x > w_upper) begin
        w_s3_next    = w_upper;
        w_s3_clipped = 1'b1;
      end else if (w_clip_x < w_lower) begin
        w_s3_next    = w_lower;
        w_s3_clipped = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S4 volume
  // ---------------------------------------------------------------------------
  logic signed [2*WIDTH:0] w_vol_x, w_vol_k, w_vol_prod, w_vol_shift;
  logic        [WIDTH-1:0] w_s4_next;

  assign w_vol_x     = {{(WIDTH+1){r_s3_data[WIDTH-1]}}, r_s3_data};
  assign w_vol_k     = {{(WIDTH+1){1'b0}}, r_s3_vol};
  assign w_vol_prod  = w_vol_x * w_vol_k;
  assign w_vol_shift = w_vol_prod >>> VOL_FRAC;
  assign w_s4_next   = r_s3_en ? f_sat(w_vol_shift) : r_s3_data;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s3_valid   <= 1'b0;
      r_s4_valid   <= 1'b0;
      r_s4_data    <= '0;
      r_s4_chan    <= '0;
      r_s4_clipped <= 1'b0;
    end else if (w_advance) begin
      // S1: capture sample and snapshot the controls with it
      r_s1_valid   <= in_valid;
      r_s1_data    <= in;
      r_s1_chan    <= in_chan;
      r_s1_en      <= enable;
      r_s1_clip_on <= (mode != 2'b00);
      r_s1_asym    <= (mode == 2'b10);
      r_s1_gain    <= gain;
      r_s1_thr     <= threshold[WIDTH-1] ? P_POS_MAX : threshold;
      r_s1_vol     <= volume;
      // S2
      r_s2_valid   <= r_s1_valid;
      r_s2_data    <= w_s2_next;
      r_s2_chan    <= r_s1_chan;
      r_s2_en      <= r_s1_en;
      r_s2_clip_on <= r_s1_clip_on;
      r_s2_asym    <= r_s1_asym;
      r_s2_thr     <= r_s1_thr;
      r_s2_vol     <= r_s1_vol;
      // S3
      r_s3_valid   <= r_s2_valid;
      r_s3_data    <= w_s3_next;
      r_s3_chan    <= r_s2_chan;
      r_s3_en      <= r_s2_en;
      r_s3_clipped <= w_s3_clipped;
      r_s3_vol     <= r_s2_vol;
      // S4 / output
      r_s4_valid   <= r_s3_valid;
      r_s4_data    <= w_s4_next;
      r_s4_chan    <= r_s3_chan;
      r_s4_clipped <= r_s3_clipped;
    end
  end

  // ---------------------------------------------------------------------------
  // Clip event counter: clear wins over a same-cycle increment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clip_count <= '0;
    end else if (clip_clear) begin
      r_clip_count <= '0;
    end else if (r_s4_valid && out_ready && r_s4_clipped && !(&r_clip_count)) begin
      r_clip_count <= r_clip_count + 1'b1;
    end
  end

  assign out         = r_s4_data;
  assign out_chan    = r_s4_chan;
  assign out_clipped = r_s4_clipped;
  assign out_valid   = r_s4_valid;
  assign clip_count  = r_clip_count;

endmodule

// File: tb/tb_distortion_pipeline.sv
// -----------------------------------------------------------------------------
// tb_distortion_pipeline
//   Self-checking bench for distortion_pipeline. Expected samples are computed
//   with plain integer arithmetic at acceptance time and queued; the pipe is
//   modelled only as a four-deep latency line that moves when the output is
//   empty or drained.
// -----------------------------------------------------------------------------
module tb_distortion_pipeline;

  localparam int W        = 16;
  localparam int CW       = 1;
  localparam int TB_CNT_W = 6;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic [1:0]          mode;
  logic [W-1:0]        in_data;
  logic [CW-1:0]       in_chan;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        gain;
  logic [W-1:0]        threshold;
  logic [W-1:0]        volume;
  logic                clip_clear;
  logic [W-1:0]        out_data;
  logic [CW-1:0]       out_chan;
  logic                out_clipped;
  logic                out_valid;
  logic                out_ready;
  logic [TB_CNT_W-1:0] clip_count;

  always #5 clk = ~clk;

  distortion_pipeline #(
    .WIDTH    (W),
    .GAIN_FRAC(8),
    .VOL_FRAC (8),
    .CHANNELS (2),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .in         (in_data),
    .in_chan    (in_chan),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .gain       (gain),
    .threshold  (threshold),
    .volume     (volume),
    .clip_clear (clip_clear),
    .out        (out_data),
    .out_chan   (out_chan),
    .out_clipped(out_clipped),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clip_count (clip_count)
  );

  typedef struct {
    int data;
    int chan;
    bit clipped;
  } exp_t;

  exp_t sb[$];
  bit   mv[4];
  int   cnt_m;
  int   checks = 0;
  int   errors = 0;
  bit   seen_valid;
  bit   last_acc;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic longint clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t ref_model(input int x, input int ch, input bit en, input int md,
                                     input longint g, input longint th, input longint vol);
    exp_t   r;
    longint p, t, lo;
    r.chan    = ch;
    r.clipped = 1'b0;
    r.data    = x;
    if (!en) return r;
    p = clamp16((longint'(x) * g) >>> 8);
    t = (th > 32767) ? 32767 : th;
    if (md != 0) begin
      lo = (md == 2) ? -(t / 2) : -t;
      if (p > t) begin
        p = t;
        r.clipped = 1'b1;
      end else if (p < lo) begin
        p = lo;
        r.clipped = 1'b1;
      end
    end
    p = clamp16((p * vol) >>> 8);
    r.data = int'(p);
    return r;
  endfunction

  // One clock: inputs were driven at the preceding negedge.
  task automatic step();
    bit   adv;
    bit   xfer_clip;
    exp_t e;
    int   xin;
    #1;
    adv        = !mv[3] || out_ready;
    seen_valid = out_valid;
    xfer_clip  = 1'b0;
    check("in_ready", in_ready, adv);
    check("out_valid", out_valid, mv[3]);
    if (mv[3]) begin
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        e = sb[0];
        check("out", $signed(out_data), e.data);
        check("out_chan", out_chan, e.chan);
        check("out_clipped", out_clipped, e.clipped);
        if (out_ready) begin
          xfer_clip = e.clipped;
          void'(sb.pop_front());
        end
      end
    end
    if (!rst_n || clip_clear) cnt_m = 0;
    else if (xfer_clip && cnt_m < CNT_MAX) cnt_m++;
    last_acc = adv && in_valid && rst_n;
    if (adv && in_valid) begin
      xin = $signed(in_data);
      sb.push_back(ref_model(xin, int'(in_chan), enable, int'(mode),
                             longint'(gain), longint'(threshold), longint'(volume)));
    end
    if (adv) begin
      mv[3] = mv[2];
      mv[2] = mv[1];
      mv[1] = mv[0];
      mv[0] = in_valid;
    end
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("clip_count", clip_count, cnt_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int x, input int ch);
    in_data  = W'(x);
    in_chan  = CW'(ch);
    in_valid = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    check("send_accept", last_acc, 1);
  endtask

  // Streams count samples (values start, start+1, ...) with in_valid held.
  task automatic stream(input int start, input int count);
    int idx;
    idx      = 0;
    in_valid = 1'b1;
    for (int c = 0; c < count + 50 && idx < count; c++) begin
      in_data = W'(start + idx);
      in_chan = CW'(idx % 2);
      step();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    check("stream_sent", idx, count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int idx;

    rst_n = 1'b0; enable = 1'b1; mode = 2'b00; in_data = '0; in_chan = '0;
    in_valid = 1'b0; gain = 16'h0100; threshold = 16'h7FFF; volume = 16'h0100;
    clip_clear = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    cnt_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_out_clipped", out_clipped, 0);
    check("rst_clip_count", clip_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Hard clip, latency
    gain = 16'h0200; threshold = 16'd1500; volume = 16'h0100; mode = 2'b01;
    send(1000, 0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      lat++;
      if (seen_valid) break;
    end
    check("t1_latency", lat, 4);
    idle(2);
    check("t1_count", clip_count, 1);

    // Asymmetric clip
    mode = 2'b10;
    send(-1000, 0);
    send(-600, 1);
    send(-300, 0);
    idle(6);

    // Gain saturation, volume floor; gain change right after acceptance
    gain = 16'h0400; threshold = 16'h7FFF; volume = 16'h0080; mode = 2'b01;
    send(32'h7000, 1);
    gain = 16'h0100;
    send(-1, 0);
    idle(6);

    // Backpressure with interleaved channels
    gain = 16'h0100; volume = 16'h0100; mode = 2'b00;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      in_data   = W'(idx + 1);
      in_chan   = CW'(idx % 2);
      out_ready = !(c >= 6 && c < 9);
      step();
      if (last_acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t4_sent", idx, 8);
    idle(6);

    // enable=0 passes through untouched
    enable = 1'b0; mode = 2'b01; threshold = 16'd10;
    send(-20000, 0);
    idle(6);
    enable = 1'b1;

    // threshold 0 in hard mode: every nonzero sample clips to 0; saturate counter
    mode = 2'b01; threshold = 16'd0; gain = 16'h0100; volume = 16'h0100;
    stream(1, CNT_MAX + 6);
    idle(6);
    check("t6_sat", clip_count, CNT_MAX);

    // Clear coincident with a clipped transfer
    send(5, 0);
    idle(3);
    clip_clear = 1'b1;
    step();
    clip_clear = 1'b0;
    check("t6_clear", clip_count, 0);

    // Reset with samples in flight
    send(7, 0);
    send(8, 1);
    send(9, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_count", clip_count, 0);
    @(negedge clk);
    idle(8);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      if (c % 23 == 0) begin
        gain      = W'($urandom_range(0, 16'h0400));
        threshold = W'($urandom);
        volume    = W'($urandom_range(0, 16'h0300));
        mode      = 2'($urandom_range(0, 3));
        enable    = ($urandom_range(0, 4) != 0);
      end
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_data    = W'($urandom);
      in_chan    = CW'($urandom_range(0, 1));
      clip_clear = ($urandom_range(0, 49) == 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; clip_clear = 1'b0; rst_n = 1'b1;
    idle(8);
    check("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
